attenuate: RTL and testbench
============================

Name: attenuate

Overview:
- Button-controlled digital attenuator in the effects chain. It is the counterpart of the gain stage: it cuts level instead of boosting it.
- Two buttons step the attenuation up or down. Each button has its own debounce and edge-detect FSM.
- Samples are divided by 2^level using an arithmetic right shift.
- A new level takes effect only at a zero crossing of the signal, or after a timeout. This prevents audible zipper clicks.
- Sits between the audio codec receive path and downstream effects. Reports the active level for the LED display.

Parameters:
- DATA_W, 16: sample width, two's-complement signed.
- LVL_W, 3: attenuation level width. Levels run 0..2^LVL_W-1; level N means shift right by N.
- DEB_CYCLES, 50000: number of consecutive stable Clk cycles a button must hold before the change is accepted.
- ZC_TIMEOUT, 64: number of accepted samples without a zero crossing after which a pending level change is forced.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Btn_up  input  1  raw, bouncy button; 1 = pressed; increases attenuation.
- Btn_down  input  1  raw, bouncy button; 1 = pressed; decreases attenuation.
- Sample_valid  input  1  one-cycle strobe; Data_in is valid in that cycle.
- Data_in  input  DATA_W  signed input sample.
- Data_out  output  DATA_W  attenuated signed sample.
- Data_out_valid  output  1  one-cycle strobe, asserted 1 cycle after Sample_valid.
- atten_level  output  LVL_W  level currently applied to samples.
- pending  output  1  high while target level differs from atten_level.

Behaviour:
- Reset (Reset low, async):
  - Data_out=0, Data_out_valid=0, atten_level=0, pending=0.
  - target=0, previous-sample sign=0, timeout counter=0, both button FSMs in IDLE.
  - Reset mid-debounce or mid-pending discards all progress.
- Button input synchronisation: each button passes through a 2-flop synchroniser before its FSM.
- Per-button FSM, states IDLE, DEB_PRESS, HELD, DEB_REL:
  - IDLE -> DEB_PRESS when the synced button is 1; counter cleared.
  - DEB_PRESS: counter increments while the button is 1. If the button reads 0, return to IDLE. When the counter reaches DEB_CYCLES-1, go to HELD and emit a one-cycle step pulse.
  - HELD -> DEB_REL when the button is 0; counter cleared. No auto-repeat: one step per press.
  - DEB_REL: counter increments while the button is 0. If the button reads 1, return to HELD. When the counter reaches DEB_CYCLES-1, go to IDLE.
- Target update, per cycle:
  - up pulse only: target+1, saturating at max level.
  - down pulse only: target-1, saturating at 0.
  - both pulses in the same cycle: no change.
- pending = (target != atten_level), registered.
- Sample path, on a cycle with Sample_valid=1:
  - Data_out <= Data_in >>> atten_level, using the atten_level value in effect before any update in that same cycle. Sign is preserved and the shift rounds toward -inf.
  - Data_out_valid <= 1 for exactly one cycle; it is 0 on all other cycles. Data_out holds its value between strobes.
  - Zero crossing is defined as: sign bit of Data_in differs from the stored previous sign, or Data_in == 0. Previous sign is updated on every valid sample.
- Level commit, on a valid sample with pending=1:
  - If a zero crossing occurs, or the timeout counter == ZC_TIMEOUT-1: atten_level moves one step toward target, and the timeout counter is cleared.
  - Otherwise the timeout counter increments.
  - When pending=0, the timeout counter is held at 0.
  - A multi-step difference therefore ramps one level per qualifying sample.
- Target change while pending: the commit direction re-evaluates against the new target. The timeout counter is not cleared.
- Latency: Data_in to Data_out is 1 cycle. A level change becomes audible on the sample following its commit.
- Sample_valid held high on consecutive cycles is legal: every cycle is treated as a sample.

Test Plan:
- Reset low mid-stream with Data_in=16'h1234 -> all outputs 0 immediately, before the next Clk edge. They stay 0 until Reset goes high and a Sample_valid arrives.
- Btn_up clean press of DEB_CYCLES cycles, then release for DEB_CYCLES cycles. Then samples +100,+50,-20 -> target=1 and pending=1. Data_out=100, 50, then -10: the -20 sample commits level 1 but is itself shifted by the old level 0, so it passes as -20; the next sample is the first one shifted by level 1. Corrected expectation: Data_out=100, 50, -20, and the next sample is halved.
- Btn_down bounce (toggle every 10 cycles, 5 times, then stable 1) -> exactly one step pulse; target decrements once. At target=0, no change: saturation.
- Eight up presses from level 0 -> target saturates at 7. Constant Data_in=+1000 with no zero crossing -> one level committed every 64 samples. Final output 1000>>>7=7.
- Btn_up and Btn_down debounced so that both step pulses land in the same cycle -> target unchanged, pending stays 0.
- Level 2, Data_in=16'h8000 (-32768) -> Data_out=16'hE000 (-8192). Data_in=-1 -> Data_out=-1.

Source files
------------

// File: rtl/attenuate.sv
// ---------------------------------------------------------------------------
// attenuate: button-controlled digital attenuator for the effects chain.
//   Each sample is divided by 2^level with an arithmetic right shift. Two
//   debounced buttons move a target level up or down. The applied level
//   follows the target one step at a time. A step is taken only at a zero
//   crossing, or after ZC_TIMEOUT samples without one, so that level changes
//   do not produce audible clicks.
// Ports:
//   Clk            system clock, rising edge
//   Reset          asynchronous, active-low reset
//   Btn_up         raw button, 1 = pressed, raises the attenuation
//   Btn_down       raw button, 1 = pressed, lowers the attenuation
//   Sample_valid   one-cycle strobe qualifying Data_in
//   Data_in        signed input sample
//   Data_out       attenuated signed sample, held between strobes
//   Data_out_valid one-cycle strobe, one cycle after Sample_valid
//   atten_level    level currently applied to samples
//   pending        high while the target level differs from atten_level
// ---------------------------------------------------------------------------

// Per-button debounce plus press detection. Emits one step pulse per press,
// with no auto-repeat.
module attenuate_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic step
);
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             sync1_r, sync2_r;
  logic             step_r, step_s;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // State, counter and registered step pulse
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      step_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      step_r  <= step_s;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (sync2_r) begin
          state_s = DEB_PRESS;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      DEB_PRESS: begin
        if (!sync2_r) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          state_s = HELD;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync2_r) begin
          state_s = DEB_REL;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = HELD;
        end
      end
      DEB_REL: begin
        if (sync2_r) begin
          state_s = HELD;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Step pulse on the last stable cycle of the press debounce
  always_comb begin
    if ((state_r == DEB_PRESS) && sync2_r && (cnt_r == CNT_LAST)) begin
      step_s = 1'b1;
    end else begin
      step_s = 1'b0;
    end
  end

  assign step = step_r;
endmodule

module attenuate #(
  parameter int DATA_W     = 16,
  parameter int LVL_W      = 3,
  parameter int DEB_CYCLES = 50000,
  parameter int ZC_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Btn_up,
  input  logic              Btn_down,
  input  logic              Sample_valid,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_out_valid,
  output logic [LVL_W-1:0]  atten_level,
  output logic              pending
);
  localparam int TMO_W = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ZC_TIMEOUT - 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = {LVL_W{1'b1}};

  logic              up_step_s, down_step_s;
  logic [LVL_W-1:0]  target_r, target_s;
  logic [LVL_W-1:0]  level_r, level_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              prev_sign_r;
  logic              pending_r;
  logic              zc_s;
  logic [DATA_W-1:0] data_out_r;
  logic              data_out_valid_r;

  attenuate_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_raw (Btn_up),
    .step    (up_step_s)
  );

  attenuate_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_raw (Btn_down),
    .step    (down_step_s)
  );

  // Target level: saturating up/down, simultaneous steps cancel
  always_comb begin
    target_s = target_r;
    if (up_step_s && !down_step_s) begin
      if (target_r != LVL_MAX) begin
        target_s = target_r + LVL_W'(1);
      end else begin
        target_s = target_r;
      end
    end else if (down_step_s && !up_step_s) begin
      if (target_r != {LVL_W{1'b0}}) begin
        target_s = target_r - LVL_W'(1);
      end else begin
        target_s = target_r;
      end
    end else begin
      target_s = target_r;
    end
  end

  // Level commit: one step toward target per qualifying sample
  always_comb begin
    level_s = level_r;
    tmo_s   = tmo_r;
    zc_s    = (Data_in[DATA_W-1] != prev_sign_r) || (Data_in == {DATA_W{1'b0}});
    if (!pending_r) begin
      tmo_s = {TMO_W{1'b0}};
    end else if (Sample_valid) begin
      if (zc_s || (tmo_r == TMO_LAST)) begin
        if (target_r > level_r) begin
          level_s = level_r + LVL_W'(1);
        end else begin
          level_s = level_r - LVL_W'(1);
        end
        tmo_s = {TMO_W{1'b0}};
      end else begin
        tmo_s = tmo_r + TMO_W'(1);
      end
    end else begin
      tmo_s = tmo_r;
    end
  end

  // Control state; pending is registered from the next-state values so it
  // always matches the registered target and level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      target_r  <= {LVL_W{1'b0}};
      level_r   <= {LVL_W{1'b0}};
      tmo_r     <= {TMO_W{1'b0}};
      pending_r <= 1'b0;
    end else begin
      target_r  <= target_s;
      level_r   <= level_s;
      tmo_r     <= tmo_s;
      pending_r <= (target_s != level_s);
    end
  end

  // Sample path: shift uses the level in effect before this cycle's commit
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_out_r       <= {DATA_W{1'b0}};
      data_out_valid_r <= 1'b0;
      prev_sign_r      <= 1'b0;
    end else begin
      data_out_valid_r <= Sample_valid;
      if (Sample_valid) begin
        data_out_r  <= DATA_W'($signed(Data_in) >>> level_r);
        prev_sign_r <= Data_in[DATA_W-1];
      end else begin
        data_out_r  <= data_out_r;
        prev_sign_r <= prev_sign_r;
      end
    end
  end

  assign Data_out       = data_out_r;
  assign Data_out_valid = data_out_valid_r;
  assign atten_level    = level_r;
  assign pending        = pending_r;
endmodule

// File: tb/tb_attenuate.sv
// Self-checking bench for attenuate. A behavioural model tracks target,
// applied level, previous sign and timeout count, and computes the expected
// output as floor division by a power of two.
module tb_attenuate;
  localparam int DEB = 16;
  localparam int ZC  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down;
  logic        sample_valid;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic [2:0]  atten_level;
  logic        pending;

  int vectors = 0;
  int errors  = 0;

  int          m_target, m_level, m_tmo;
  logic        m_prev_sign;
  logic [15:0] m_out;

  attenuate #(.DATA_W(16), .LVL_W(3), .DEB_CYCLES(DEB), .ZC_TIMEOUT(ZC)) dut (
    .Clk            (clk),
    .Reset          (rst_n),
    .Btn_up         (btn_up),
    .Btn_down       (btn_down),
    .Sample_valid   (sample_valid),
    .Data_in        (data_in),
    .Data_out       (data_out),
    .Data_out_valid (data_out_valid),
    .atten_level    (atten_level),
    .pending        (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div_pow2(input int x, input int l);
    int d;
    d = 1 << l;
    if (x >= 0) return x / d;
    else return -((-x + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_target = 0; m_level = 0; m_tmo = 0; m_prev_sign = 1'b0; m_out = 16'h0000;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},  data_out, 0);
    chk({tag, "_dval"},  data_out_valid, 0);
    chk({tag, "_level"}, atten_level, 0);
    chk({tag, "_pend"},  pending, 0);
  endtask

  // Applies one sample and checks the result one clock later.
  // sample_valid stays high; idle() drops it.
  task automatic send(input logic [15:0] x);
    int   xi;
    logic zc;
    xi = int'($signed(x));
    m_out = 16'(floor_div_pow2(xi, m_level));
    zc = (x[15] != m_prev_sign) || (xi == 0);
    m_prev_sign = x[15];
    if (m_target != m_level) begin
      if (zc || m_tmo == ZC - 1) begin
        m_level = (m_target > m_level) ? m_level + 1 : m_level - 1;
        m_tmo = 0;
      end else begin
        m_tmo++;
      end
    end else begin
      m_tmo = 0;
    end
    data_in = x;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    chk("dout",   data_out, m_out);
    chk("dvalid", data_out_valid, 1);
    chk("level",  atten_level, m_level);
    chk("pend",   pending, (m_target != m_level));
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_dval", data_out_valid, 0);
      chk("idle_hold", data_out, m_out);
    end
  endtask

  task automatic apply_step(input logic up, input logic dn);
    if (up && !dn) m_target = (m_target == 7) ? 7 : m_target + 1;
    else if (dn && !up) m_target = (m_target == 0) ? 0 : m_target - 1;
    else m_target = m_target;
    if (m_target == m_level) m_tmo = 0;
    chk("press_pend",  pending, (m_target != m_level));
    chk("press_level", atten_level, m_level);
  endtask

  task automatic press(input logic up, input logic dn);
    sample_valid = 1'b0;
    btn_up = up; btn_down = dn;
    repeat (DEB + 8) @(posedge clk);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (DEB + 8) @(posedge clk);
    #1;
    apply_step(up, dn);
  endtask

  initial begin
    logic [15:0] x;
    int          r;
    int          presses;
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    sample_valid = 1'b0; data_in = 16'h0000;
    model_reset();

    // Power-on reset
    #2;
    chk_all_zero("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Build up state, then reset mid-stream
    press(1'b1, 1'b0);
    send(16'h0000);
    press(1'b1, 1'b0);
    send(16'h1234);
    chk("pre_rst_dout", data_out, 16'h091A);
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    sample_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("post_rst");

    // Single up press, commit on the -20 zero crossing
    press(1'b1, 1'b0);
    chk("tp2_pend", pending, 1);
    send(16'd100);
    chk("tp2_s1", data_out, 16'd100);
    send(16'd50);
    chk("tp2_s2", data_out, 16'd50);
    send(16'hFFEC);
    chk("tp2_s3", data_out, 16'hFFEC);
    send(16'd40);
    chk("tp2_s4", data_out, 16'd20);
    chk("tp2_lvl", atten_level, 1);
    idle(2);

    // Bouncy down button yields one step
    btn_down = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_down = ~btn_down;
      repeat (10) @(posedge clk);
    end
    repeat (DEB + 8) @(posedge clk);
    btn_down = 1'b0;
    repeat (DEB + 8) @(posedge clk);
    #1;
    apply_step(1'b0, 1'b1);
    chk("bounce_pend", pending, 1);
    send(16'h0000);
    chk("bounce_lvl", atten_level, 0);
    press(1'b0, 1'b1);
    chk("sat_low_pend", pending, 0);

    // Both buttons together cancel
    press(1'b1, 1'b1);
    chk("both_pend", pending, 0);
    send(16'd5);
    chk("both_dout", data_out, 16'd5);

    // Eight up presses saturate at 7; constant input forces timeout commits
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
    chk("sat_hi_pend", pending, 1);
    for (int i = 0; i < ZC; i++) send(16'd1000);
    chk("tmo_first", atten_level, 1);
    for (int i = 0; i < 6 * ZC; i++) send(16'd1000);
    chk("tmo_last", atten_level, 7);
    send(16'd1000);
    chk("lvl7_dout", data_out, 16'd7);
    idle(1);

    // Down to level 2, then the negative extremes
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send(16'h0000);
    chk("lvl2", atten_level, 2);
    send(16'h8000);
    chk("min_dout", data_out, 16'hE000);
    send(16'hFFFF);
    chk("neg1_dout", data_out, 16'hFFFF);

    // Randomised stream with occasional presses
    presses = 0;
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14) begin
        x = 16'($urandom);
        if ($urandom_range(0, 15) == 0) x = 16'h0000;
        send(x);
      end else if (r < 19 || presses >= 8) begin
        idle(1);
      end else begin
        presses++;
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
